// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline write-back and buffered load responses.
// Optional define WB_FAIR_EN: alternate contested grants between the load buffer and the pipeline.
module wb_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LQ_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    output logic                  pipe_ready,
    input  logic                  ld_issue_valid,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    output logic                  ld_issue_ready,
    input  logic                  ld_rsp_valid,
    input  logic [REG_ADDR_W-1:0] ld_rsp_rd,
    input  logic [XLEN-1:0]       ld_rsp_data,
    output logic                  ld_rsp_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  hazard,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata
);

    localparam int NREGS = 1 << REG_ADDR_W;
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(LQ_DEPTH);

    logic [REG_ADDR_W-1:0] lq_rd_r   [LQ_DEPTH];
    logic [XLEN-1:0]       lq_data_r [LQ_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W:0]        count_r;
    logic [NREGS-1:0]      pending_r;
    logic                  rf_we_r;
    logic [REG_ADDR_W-1:0] rf_waddr_r;
    logic [XLEN-1:0]       rf_wdata_r;
`ifdef WB_FAIR_EN
    logic                  last_load_r;
`endif

    logic                  full_s;
    logic                  empty_s;
    logic                  pipe_elig_s;
    logic                  contested_s;
    logic                  load_win_s;
    logic                  pipe_win_s;
    logic                  enq_s;
    logic                  issue_acc_s;
    logic [REG_ADDR_W-1:0] head_rd_s;
    logic [XLEN-1:0]       head_data_s;
    logic [REG_ADDR_W-1:0] win_rd_s;
    logic [XLEN-1:0]       win_data_s;
    logic [NREGS-1:0]      clr_mask_s;
    logic [NREGS-1:0]      set_mask_s;
    logic [NREGS-1:0]      pending_nxt_s;

    assign full_s      = (count_r == CNT_FULL);
    assign empty_s     = (count_r == {(PTR_W + 1){1'b0}});
    assign head_rd_s   = lq_rd_r[rd_ptr_r];
    assign head_data_s = lq_data_r[rd_ptr_r];

    // Handshakes are withheld during reset so nothing is accepted into state that is being cleared.
    assign ld_rsp_ready   = !full_s && !reset;
    assign ld_issue_ready = !pending_r[ld_issue_rd] && !reset;
    assign hazard         = (pending_r[rs1_addr] || pending_r[rs2_addr]) && !reset;
    assign pipe_ready     = pipe_win_s;
    assign enq_s          = ld_rsp_valid && ld_rsp_ready;
    assign issue_acc_s    = ld_issue_valid && ld_issue_ready;

    // Winner selection between the buffered load head and the pipeline result
    always_comb begin
        pipe_elig_s = pipe_valid && !pending_r[pipe_rd] && !reset;
        contested_s = !empty_s && pipe_elig_s;
        load_win_s  = 1'b0;
        pipe_win_s  = 1'b0;
        if (reset) begin
            load_win_s = 1'b0;
            pipe_win_s = 1'b0;
        end else if (contested_s) begin
`ifdef WB_FAIR_EN
            load_win_s = !last_load_r;
`else
            load_win_s = 1'b1;
`endif
            pipe_win_s = !load_win_s;
        end else begin
            load_win_s = !empty_s;
            pipe_win_s = pipe_elig_s;
        end
        if (load_win_s) begin
            win_rd_s   = head_rd_s;
            win_data_s = head_data_s;
        end else begin
            win_rd_s   = pipe_rd;
            win_data_s = pipe_data;
        end
    end

    // Scoreboard update: clear on load win, then set on issue so a same-index set wins
    always_comb begin
        clr_mask_s              = {NREGS{1'b0}};
        set_mask_s              = {NREGS{1'b0}};
        clr_mask_s[head_rd_s]   = load_win_s;
        set_mask_s[ld_issue_rd] = issue_acc_s && (ld_issue_rd != {REG_ADDR_W{1'b0}});
        pending_nxt_s           = (pending_r & ~clr_mask_s) | set_mask_s;
    end

    // Load buffer payload storage
    always_ff @(posedge clk) begin
        if (enq_s) begin
            lq_rd_r[wr_ptr_r]   <= ld_rsp_rd;
            lq_data_r[wr_ptr_r] <= ld_rsp_data;
        end
    end

    // Load buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (load_win_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({enq_s, load_win_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Scoreboard and registered register-file write; rd=0 winners are consumed without a write
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r  <= {NREGS{1'b0}};
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {REG_ADDR_W{1'b0}};
            rf_wdata_r <= {XLEN{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
            rf_we_r   <= (load_win_s || pipe_win_s) && (win_rd_s != {REG_ADDR_W{1'b0}});
            if (load_win_s || pipe_win_s) begin
                rf_waddr_r <= win_rd_s;
                rf_wdata_r <= win_data_s;
            end
        end
    end

`ifdef WB_FAIR_EN
    // Remember which source took the last contested grant
    always_ff @(posedge clk) begin
        if (reset) begin
            last_load_r <= 1'b0;
        end else if (contested_s) begin
            last_load_r <= load_win_s;
        end
    end
`endif

    assign rf_we    = rf_we_r;
    assign rf_waddr = rf_waddr_r;
    assign rf_wdata = rf_wdata_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;
    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int LQD  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            pipe_valid;
    logic [RAW-1:0]  pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            pipe_ready;
    logic            ld_issue_valid;
    logic [RAW-1:0]  ld_issue_rd;
    logic            ld_issue_ready;
    logic            ld_rsp_valid;
    logic [RAW-1:0]  ld_rsp_rd;
    logic [XLEN-1:0] ld_rsp_data;
    logic            ld_rsp_ready;
    logic [RAW-1:0]  rs1_addr;
    logic [RAW-1:0]  rs2_addr;
    logic            hazard;
    logic            rf_we;
    logic [RAW-1:0]  rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    always #5 clk = ~clk;

    wb_port_arbiter #(.XLEN(XLEN), .REG_ADDR_W(RAW), .LQ_DEPTH(LQD)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
        .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_rd(ld_rsp_rd), .ld_rsp_data(ld_rsp_data),
        .ld_rsp_ready(ld_rsp_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: load buffer as a queue, pending registers as a flag array
    typedef struct packed {
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            lq[$];
    bit              pend [32];
`ifdef WB_FAIR_EN
    bit              m_last_load;
`endif
    bit              m_we;
    logic [RAW-1:0]  m_waddr;
    logic [XLEN-1:0] m_wdata;
    bit              acc_pipe;
    bit              acc_iss;
    bit              acc_rsp;
    logic [RAW-1:0]  inflight[$];

    // One clock cycle: called just after a falling edge with inputs applied, returns at the next falling edge.
    task automatic cycle();
        bit   lw;
        bit   pw;
        bit   contested;
        bit   exp_ir;
        bit   exp_rr;
        bit   exp_hz;
        ent_t head;
        #1;
        lw = 1'b0; pw = 1'b0; contested = 1'b0; exp_ir = 1'b0; exp_rr = 1'b0; exp_hz = 1'b0;
        if (!reset) begin
            contested = (lq.size() != 0) && pipe_valid && !pend[pipe_rd];
            if (contested) begin
`ifdef WB_FAIR_EN
                lw = !m_last_load;
`else
                lw = 1'b1;
`endif
                pw = !lw;
            end else begin
                lw = (lq.size() != 0);
                pw = pipe_valid && !pend[pipe_rd];
            end
            exp_ir = !pend[ld_issue_rd];
            exp_rr = (lq.size() < LQD);
            exp_hz = pend[rs1_addr] || pend[rs2_addr];
        end
        check_val("pipe_ready", 32'(pipe_ready), 32'(pw));
        check_val("ld_issue_ready", 32'(ld_issue_ready), 32'(exp_ir));
        check_val("ld_rsp_ready", 32'(ld_rsp_ready), 32'(exp_rr));
        check_val("hazard", 32'(hazard), 32'(exp_hz));
        acc_pipe = pw;
        acc_iss  = ld_issue_valid && exp_ir;
        acc_rsp  = ld_rsp_valid && exp_rr;
        @(posedge clk);
        #1;
        if (reset) begin
            lq.delete();
            foreach (pend[i]) pend[i] = 1'b0;
`ifdef WB_FAIR_EN
            m_last_load = 1'b0;
`endif
            m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            if (lw) begin
                head = lq.pop_front();
                pend[head.rd] = 1'b0;
                m_we = (head.rd != 0); m_waddr = head.rd; m_wdata = head.data;
            end else if (pw) begin
                m_we = (pipe_rd != 0); m_waddr = pipe_rd; m_wdata = pipe_data;
            end else begin
                m_we = 1'b0;
            end
`ifdef WB_FAIR_EN
            if (contested) m_last_load = lw;
`endif
            if (acc_rsp) lq.push_back('{rd: ld_rsp_rd, data: ld_rsp_data});
            if (acc_iss && ld_issue_rd != 0) pend[ld_issue_rd] = 1'b1;
        end
        check_val("rf_we", 32'(rf_we), 32'(m_we));
        check_val("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
        check_val("rf_wdata", rf_wdata, m_wdata);
        @(negedge clk);
    endtask

    task automatic idle();
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        ld_issue_valid = 1'b0; ld_issue_rd = '0;
        ld_rsp_valid = 1'b0; ld_rsp_rd = '0; ld_rsp_data = '0;
        rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        inflight.delete();
    endtask

    logic [RAW-1:0] seq [3];
    int             exp_seq [3];
    int             nw;
    int             k_rsp;

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        cycle();
        cycle();
        check_val("rst_we", 32'(rf_we), 32'd0);
        check_val("rst_waddr", 32'(rf_waddr), 32'd0);
        check_val("rst_wdata", rf_wdata, 32'd0);
        check_val("rst_rsp_rdy", 32'(ld_rsp_ready), 32'd0);
        reset = 1'b0;

        // Single pipeline write
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234;
        cycle();
        pipe_valid = 1'b0;
        check_val("p5_we", 32'(rf_we), 32'd1);
        check_val("p5_addr", 32'(rf_waddr), 32'd5);
        check_val("p5_data", rf_wdata, 32'h1234);

        // Load to r7: hazard until the write lands two cycles after the response
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
        cycle();
        ld_issue_valid = 1'b0; rs1_addr = 5'd7;
        #1 check_val("haz7", 32'(hazard), 32'd1);
        ld_rsp_valid = 1'b1; ld_rsp_rd = 5'd7; ld_rsp_data = 32'hCAFE;
        cycle();
        ld_rsp_valid = 1'b0;
        check_val("haz7_q", 32'(hazard), 32'd1);
        check_val("l7_notyet", 32'(rf_we), 32'd0);
        cycle();
        check_val("l7_we", 32'(rf_we), 32'd1);
        check_val("l7_addr", 32'(rf_waddr), 32'd7);
        check_val("l7_data", rf_wdata, 32'hCAFE);
        check_val("haz7_clr", 32'(hazard), 32'd0);

        // WAW: pipe to r3 waits behind the pending load to r3
        rs1_addr = '0;
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd3;
        cycle();
        ld_issue_valid = 1'b0;
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
        #1 check_val("waw_block", 32'(pipe_ready), 32'd0);
        cycle();
        ld_rsp_valid = 1'b1; ld_rsp_rd = 5'd3; ld_rsp_data = 32'h3333;
        cycle();
        ld_rsp_valid = 1'b0;
        check_val("waw_block2", 32'(pipe_ready), 32'd0);
        cycle();
        check_val("waw_l_addr", 32'(rf_waddr), 32'd3);
        check_val("waw_l_data", rf_wdata, 32'h3333);
        check_val("waw_go", 32'(pipe_ready), 32'd1);
        cycle();
        pipe_valid = 1'b0;
        check_val("waw_p_we", 32'(rf_we), 32'd1);
        check_val("waw_p_data", rf_wdata, 32'h33);

        // Back-to-back responses against a continuous pipeline stream
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ld_issue_valid = 1'b1; ld_issue_rd = RAW'(10 + k);
            cycle();
        end
        ld_issue_valid = 1'b0;
        ld_rsp_valid = 1'b1; ld_rsp_rd = 5'd10; ld_rsp_data = 32'hA0;
        cycle();
        ld_rsp_rd = 5'd11; ld_rsp_data = 32'hA1;
        pipe_valid = 1'b1; pipe_rd = 5'd20; pipe_data = 32'h200;
        nw = 0; k_rsp = 1;
        foreach (seq[i]) seq[i] = 5'd31;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (rf_we && nw < 3) begin
                seq[nw] = rf_waddr;
                nw++;
            end
            if (acc_pipe) begin
                pipe_rd = pipe_rd + 5'd1; pipe_data = pipe_data + 32'd1;
            end
            if (acc_rsp) begin
                k_rsp++;
                if (k_rsp < 4) begin
                    ld_rsp_rd = RAW'(10 + k_rsp); ld_rsp_data = 32'(32'hA0 + k_rsp);
                end else begin
                    ld_rsp_valid = 1'b0;
                end
            end
        end
`ifdef WB_FAIR_EN
        exp_seq[0] = 10; exp_seq[1] = 20; exp_seq[2] = 11;
`else
        exp_seq[0] = 10; exp_seq[1] = 11; exp_seq[2] = 12;
`endif
        for (int i = 0; i < 3; i++) check_val($sformatf("order%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        idle();
        repeat (4) cycle();

        // Destination r0: consumed without a write, never marked pending
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hDEAD;
        #1 check_val("p0_rdy", 32'(pipe_ready), 32'd1);
        cycle();
        pipe_valid = 1'b0;
        check_val("p0_we", 32'(rf_we), 32'd0);
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
        #1 check_val("i0_rdy", 32'(ld_issue_ready), 32'd1);
        cycle();
        ld_issue_valid = 1'b0;
        #1 check_val("i0_haz", 32'(hazard), 32'd0);

        // Reset with a buffered load and pending registers
        do_reset();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd12;
        cycle();
        ld_issue_rd = 5'd13;
        cycle();
        ld_issue_valid = 1'b0;
        ld_rsp_valid = 1'b1; ld_rsp_rd = 5'd12; ld_rsp_data = 32'h1212;
        cycle();
        ld_rsp_rd = 5'd13; ld_rsp_data = 32'h1313;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        idle();
        rs1_addr = 5'd13; rs2_addr = 5'd12;
        #1;
        check_val("mr_haz", 32'(hazard), 32'd0);
        check_val("mr_we", 32'(rf_we), 32'd0);
        check_val("mr_empty", 32'(ld_rsp_ready), 32'd1);
        repeat (4) cycle();

        // Randomized traffic with an in-order memory model and a mid-run reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = (c == 1500 || c == 1501) ? 1'b1 : 1'b0;
            rs1_addr = RAW'($urandom_range(0, 7));
            rs2_addr = RAW'($urandom_range(0, 7));
            cycle();
            if (reset) begin
                inflight.delete();
                pipe_valid = 1'b0; ld_issue_valid = 1'b0; ld_rsp_valid = 1'b0;
            end else begin
                if (acc_iss) inflight.push_back(ld_issue_rd);
                if (acc_pipe || !pipe_valid) begin
                    pipe_valid = ($urandom_range(0, 2) != 0);
                    pipe_rd    = RAW'($urandom_range(0, 7));
                    pipe_data  = $urandom;
                end
                if (acc_iss || !ld_issue_valid) begin
                    ld_issue_valid = ($urandom_range(0, 2) == 0);
                    ld_issue_rd    = RAW'($urandom_range(0, 7));
                end
                if (acc_rsp || !ld_rsp_valid) begin
                    if (inflight.size() != 0 && $urandom_range(0, 1) == 1) begin
                        ld_rsp_valid = 1'b1;
                        ld_rsp_rd    = inflight.pop_front();
                        ld_rsp_data  = $urandom;
                    end else begin
                        ld_rsp_valid = 1'b0;
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
